f_out_stage: RTL

//  Output stage that sits directly after the ALU function mux (f_mux).

---
 rtl/f_out_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/f_out_stage.sv
// Output stage after the ALU function mux: 2-entry skid buffer with a
// valid/ready handshake, NZCV status register with carry feedback, and an
// accepted-result counter.
module f_out_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] fin,
  input  logic                  ni,
  input  logic                  zi,
  input  logic                  ci,
  input  logic                  vi,
  input  logic                  flag_we,
  input  logic                  flag_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [3:0]            dflags,
  output logic [3:0]            nzcv,
  output logic                  c_fb,
  output logic [CNT_WIDTH-1:0]  acc_cnt
);

  // Buffer entry layout: {result, n, z, c, v}
  localparam int unsigned PW = DATA_WIDTH + 4;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [PW-1:0]        main_q, main_d;
  logic [PW-1:0]        skid_q, skid_d;
  logic [3:0]           nzcv_q, nzcv_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic          acc_in;
  logic          acc_out;
  logic [PW-1:0] in_word;

  assign acc_in  = in_valid & in_ready_q;
  assign acc_out = out_valid_q & out_ready;
  assign in_word = {fin, ni, zi, ci, vi};

  // Next-state, buffer steering, status register and counter update
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    nzcv_d      = nzcv_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      EMPTY: begin
        if (acc_in) begin
          state_d = ONE;
          main_d  = in_word;
        end
      end
      ONE: begin
        if (acc_in && acc_out) begin
          main_d = in_word;
        end else if (acc_in) begin
          state_d = TWO;
          skid_d  = in_word;
        end else if (acc_out) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Upstream is stalled here, so only a drain can happen
        if (acc_out) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);

    // Clear wins over a same-cycle flag load
    if (flag_clr) begin
      nzcv_d = 4'b0000;
    end else if (acc_in && flag_we) begin
      nzcv_d = {ni, zi, ci, vi};
    end

    if (acc_in) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
      nzcv_q      <= 4'b0000;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      nzcv_q      <= nzcv_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign dout      = main_q[PW-1:4];
  assign dflags    = main_q[3:0];
  assign nzcv      = nzcv_q;
  assign c_fb      = nzcv_q[1];
  assign acc_cnt   = cnt_q;

endmodule
